// File: rtl/mvm_result_requant_pack_if.sv
// Stream interface for the MVM result requantise/pack block: one result item
// per beat in, one packed lane word per emitted vector chunk out.
interface mvm_result_requant_pack_if #(
    parameter int S = 48,
    parameter int N = 8,
    parameter int P = 16
);
    logic [S-1:0]   i_sum;
    logic           i_first;
    logic           i_last;
    logic           i_pause;
    logic [5:0]     i_shift;
    logic           i_relu;
    logic [P*N-1:0] o_data;
    logic [P-1:0]   o_lane_en;
    logic           o_valid;
    logic           o_first;
    logic           o_last;
    logic           o_sat;
    logic           o_err;

    modport slave (
        input  i_sum, i_first, i_last, i_pause, i_shift, i_relu,
        output o_data, o_lane_en, o_valid, o_first, o_last, o_sat, o_err
    );

    modport master (
        output i_sum, i_first, i_last, i_pause, i_shift, i_relu,
        input  o_data, o_lane_en, o_valid, o_first, o_last, o_sat, o_err
    );
endinterface

// File: rtl/mvm_result_requant_pack.sv
// Requantises S-bit dot-product results to N-bit lanes (round half up,
// optional ReLU, saturate) and packs P lanes per output word. Three register
// stages: framing + round, saturate, pack/output.
module mvm_result_requant_pack #(
    parameter int S = 48,
    parameter int N = 8,
    parameter int P = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    mvm_result_requant_pack_if.slave     io_bus
);
    localparam int LW = (P > 1) ? $clog2(P) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(P - 1);
    localparam logic [5:0]    SHIFT_MAX = 6'(S - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_VEC = 1'b1;

    // Framing state and per-vector captured controls
    logic [0:0]    r_state;
    logic [LW-1:0] r_cnt;
    logic [5:0]    r_shift;
    logic          r_relu;

    // Stage 1: rounded item plus routing flags
    logic          r_s1_v, r_s1_first, r_s1_last, r_s1_emit, r_s1_relu, r_s1_err;
    logic [LW-1:0] r_s1_lane;
    logic signed [S:0] r_s1_rnd;

    // Stage 2: saturated lane value
    logic          r_s2_v, r_s2_first, r_s2_last, r_s2_emit, r_s2_err, r_s2_sat;
    logic [LW-1:0] r_s2_lane;
    logic [N-1:0]  r_s2_val;

    // Stage 3: word under construction
    logic [P*N-1:0] r_acc_data;
    logic [P-1:0]   r_acc_en;
    logic           r_acc_sat;
    logic           r_acc_first;

    logic          w_beat, w_take, w_err, w_emit, w_relu;
    logic [LW-1:0] w_lane, w_cnt_nxt;
    logic [0:0]    w_state_nxt;
    logic [5:0]    w_shift_raw, w_shift;
    logic signed [S:0] w_sum_ext, w_bias, w_rnd;

    logic          w_fits, w_sat;
    logic [N-1:0]  w_val;

    logic [P*N-1:0] w_base_data, w_word_data;
    logic [P-1:0]   w_base_en, w_word_en;
    logic           w_word_sat, w_word_first, w_out;

    // Round half up in S+1 bits; the first beat of a vector uses the live controls
    always_comb begin
        w_shift_raw = io_bus.i_first ? io_bus.i_shift : r_shift;
        w_shift     = (w_shift_raw > SHIFT_MAX) ? SHIFT_MAX : w_shift_raw;
        w_relu      = io_bus.i_first ? io_bus.i_relu : r_relu;
        w_sum_ext   = {io_bus.i_sum[S-1], io_bus.i_sum};
        w_bias      = (w_shift != 6'd0) ? ((S+1)'(1) << (w_shift - 6'd1)) : '0;
        w_rnd       = (w_sum_ext + w_bias) >>> w_shift;
    end

    // Vector framing: lane selection, word boundaries and framing errors
    always_comb begin
        w_beat      = ~io_bus.i_pause;
        w_take      = 1'b0;
        w_err       = 1'b0;
        w_lane      = r_cnt;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        if (w_beat) begin
            if (io_bus.i_first) begin
                w_take = 1'b1;
                w_lane = '0;
                w_err  = (r_state == ST_IN_VEC);
            end else if (r_state == ST_IN_VEC) begin
                w_take = 1'b1;
            end else begin
                w_err  = 1'b1;
            end
            if (w_take) begin
                w_cnt_nxt   = (w_lane == LANE_LAST) ? '0 : w_lane + 1'b1;
                w_state_nxt = io_bus.i_last ? ST_IDLE : ST_IN_VEC;
            end
        end
        w_emit = w_take & (io_bus.i_last | (w_lane == LANE_LAST));
    end

    // Framing registers and stage-1 pipeline register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_s1_v     <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_emit  <= 1'b0;
            r_s1_relu  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_lane  <= '0;
            r_s1_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_beat && io_bus.i_first) begin
                r_shift <= io_bus.i_shift;
                r_relu  <= io_bus.i_relu;
            end
            r_s1_v     <= w_take;
            r_s1_first <= w_take & io_bus.i_first;
            r_s1_last  <= w_take & io_bus.i_last;
            r_s1_emit  <= w_emit;
            r_s1_relu  <= w_relu;
            r_s1_err   <= w_err;
            r_s1_lane  <= w_lane;
            r_s1_rnd   <= w_rnd;
        end
    end

    // ReLU then clip to the signed N-bit range; ReLU zeroing is not a saturation
    always_comb begin
        w_fits = (&r_s1_rnd[S:N-1]) | ~(|r_s1_rnd[S:N-1]);
        w_sat  = 1'b0;
        w_val  = r_s1_rnd[N-1:0];
        if (r_s1_relu && r_s1_rnd[S]) begin
            w_val = '0;
        end else if (!w_fits) begin
            w_sat = 1'b1;
            w_val = r_s1_rnd[S] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    // Stage-2 pipeline register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s2_v     <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_emit  <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_lane  <= '0;
            r_s2_val   <= '0;
        end else begin
            r_s2_v     <= r_s1_v;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_emit  <= r_s1_emit;
            r_s2_err   <= r_s1_err;
            r_s2_sat   <= w_sat;
            r_s2_lane  <= r_s1_lane;
            r_s2_val   <= w_val;
        end
    end

    // Lane 0 always opens a fresh word, which also discards an abandoned partial word
    always_comb begin
        w_base_data  = (r_s2_lane == '0) ? '0 : r_acc_data;
        w_base_en    = (r_s2_lane == '0) ? '0 : r_acc_en;
        w_word_sat   = ((r_s2_lane == '0) ? 1'b0 : r_acc_sat) | r_s2_sat;
        w_word_first = (r_s2_lane == '0) ? r_s2_first : r_acc_first;
        w_word_data  = w_base_data;
        w_word_data[r_s2_lane*N +: N] = r_s2_val;
        w_word_en    = w_base_en | (P'(1) << r_s2_lane);
        w_out        = r_s2_v & r_s2_emit;
    end

    // Word accumulator and output register; data and lane mask hold between words
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc_data       <= '0;
            r_acc_en         <= '0;
            r_acc_sat        <= 1'b0;
            r_acc_first      <= 1'b0;
            io_bus.o_data    <= '0;
            io_bus.o_lane_en <= '0;
            io_bus.o_valid   <= 1'b0;
            io_bus.o_first   <= 1'b0;
            io_bus.o_last    <= 1'b0;
            io_bus.o_sat     <= 1'b0;
            io_bus.o_err     <= 1'b0;
        end else begin
            if (r_s2_v) begin
                r_acc_data  <= w_word_data;
                r_acc_en    <= w_word_en;
                r_acc_sat   <= w_word_sat;
                r_acc_first <= w_word_first;
            end
            if (w_out) begin
                io_bus.o_data    <= w_word_data;
                io_bus.o_lane_en <= w_word_en;
            end
            io_bus.o_valid <= w_out;
            io_bus.o_first <= w_out & w_word_first;
            io_bus.o_last  <= w_out & r_s2_last;
            io_bus.o_sat   <= w_out & w_word_sat;
            io_bus.o_err   <= r_s2_err;
        end
    end
endmodule

// File: tb/tb_mvm_result_requant_pack.sv
// Bench for mvm_result_requant_pack: directed table of single-item vectors,
// hand-written framing/reset/pause sequences and randomized streams checked
// against a list-based reference model.
module tb_mvm_result_requant_pack;
    localparam int S = 48;
    localparam int N = 8;
    localparam int P = 16;
    localparam longint MAXV = (longint'(1) <<< (N - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mvm_result_requant_pack_if #(.S(S), .N(N), .P(P)) bus ();

    mvm_result_requant_pack #(.S(S), .N(N), .P(P)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus.slave)
    );

    typedef struct {
        int             stamp;
        logic [P*N-1:0] data;
        logic [P-1:0]   en;
        bit             first;
        bit             last;
        bit             sat;
    } word_t;

    typedef struct {
        logic [S-1:0] sum;
        logic [5:0]   shift;
        bit           first;
        bit           last;
        bit           pause;
        bit           relu;
        bit           rst;
    } beat_t;

    typedef struct {
        logic [S-1:0] sum;
        logic [5:0]   sh;
        bit           relu;
        logic [N-1:0] lane0;
        bit           sat;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rst_at_edge = 1'b1;
    bit mon_on = 1'b0;
    logic [P*N-1:0] held = '0;

    word_t got_q[$];
    word_t exp_q[$];
    int    got_err[$];
    int    exp_err[$];
    beat_t beats[$];
    vec_t  tbl[15];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pk(input word_t w);
        return {w.stamp, w.data, w.en, w.first, w.last, w.sat};
    endfunction

    // Output collector and hold check on o_data between words
    always @(negedge clk) begin
        word_t w;
        if (mon_on) begin
            if (rst_at_edge) held = '0;
            if (bus.o_valid) begin
                w.stamp = cyc;
                w.data  = bus.o_data;
                w.en    = bus.o_lane_en;
                w.first = bus.o_first;
                w.last  = bus.o_last;
                w.sat   = bus.o_sat;
                got_q.push_back(w);
                held = bus.o_data;
            end else begin
                check("hold", bus.o_data, held);
            end
            if (bus.o_err) got_err.push_back(cyc);
        end
    end

    // Reference requantisation in 64-bit integer arithmetic
    function automatic logic [N-1:0] req(input logic [S-1:0] sum, input logic [5:0] sh,
                                         input bit relu, output bit sat);
        longint s, r;
        int k;
        s = longint'($signed(sum));
        k = (int'(sh) > S - 1) ? S - 1 : int'(sh);
        r = (s + ((k > 0) ? (longint'(1) <<< (k - 1)) : longint'(0))) >>> k;
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        else if (r > MAXV) begin r = MAXV; sat = 1'b1; end
        else if (r < MINV) begin r = MINV; sat = 1'b1; end
        return r[N-1:0];
    endfunction

    function automatic void add_beat(input logic [S-1:0] sum, input bit first, input bit last,
                                     input logic [5:0] sh, input bit relu);
        beat_t b;
        b.sum = sum; b.first = first; b.last = last; b.shift = sh; b.relu = relu;
        b.pause = 1'b0; b.rst = 1'b0;
        beats.push_back(b);
    endfunction

    function automatic void add_pause();
        beat_t b;
        b.sum = S'({$urandom(), $urandom()}); b.first = 1'($urandom());
        b.last = 1'($urandom()); b.shift = 6'($urandom()); b.relu = 1'($urandom());
        b.pause = 1'b1; b.rst = 1'b0;
        beats.push_back(b);
    endfunction

    function automatic void add_rst();
        beat_t b;
        b.sum = '0; b.first = 1'b0; b.last = 1'b0; b.shift = '0; b.relu = 1'b0;
        b.pause = 1'b1; b.rst = 1'b1;
        beats.push_back(b);
    endfunction

    function automatic logic [S-1:0] rand_sum();
        logic signed [S-1:0] x;
        x = S'({$urandom(), $urandom()});
        return x >>> $urandom_range(S - 1, 0);
    endfunction

    // Model: items gathered per vector, chunked into P-lane words, each word
    // appearing two edges after the edge that sampled its completing item
    task automatic build_model(input int base);
        bit open;
        logic [5:0] vsh;
        bit vrelu;
        int nitems, widx;
        word_t cur;
        int resets[$];
        open = 1'b0; vsh = '0; vrelu = 1'b0; nitems = 0; widx = 0;
        cur.stamp = 0; cur.data = '0; cur.en = '0; cur.first = 0; cur.last = 0; cur.sat = 0;
        for (int j = 0; j < beats.size(); j++) begin
            int e;
            bit s;
            logic [N-1:0] v;
            e = base + j;
            if (beats[j].rst) begin
                open = 1'b0;
                resets.push_back(e);
                continue;
            end
            if (beats[j].pause) continue;
            if (beats[j].first) begin
                if (open) exp_err.push_back(e + 2);
                open = 1'b1; vsh = beats[j].shift; vrelu = beats[j].relu;
                widx = 0; nitems = 0;
            end else if (!open) begin
                exp_err.push_back(e + 2);
                continue;
            end
            v = req(beats[j].sum, vsh, vrelu, s);
            if (nitems == 0) begin
                cur.data = '0; cur.en = '0; cur.sat = 1'b0;
            end
            cur.data[nitems*N +: N] = v;
            cur.en[nitems] = 1'b1;
            cur.sat = cur.sat | s;
            nitems++;
            if (nitems == P || beats[j].last) begin
                cur.stamp = e + 2;
                cur.first = (widx == 0);
                cur.last  = beats[j].last;
                exp_q.push_back(cur);
                widx++;
                nitems = 0;
            end
            if (beats[j].last) open = 1'b0;
        end
        // A reset edge while a word or error is still in the pipeline kills it
        foreach (resets[r]) begin
            word_t keep[$];
            int    keep_e[$];
            foreach (exp_q[i])
                if (!(exp_q[i].stamp - 2 < resets[r] && resets[r] <= exp_q[i].stamp))
                    keep.push_back(exp_q[i]);
            foreach (exp_err[i])
                if (!(exp_err[i] - 2 < resets[r] && resets[r] <= exp_err[i]))
                    keep_e.push_back(exp_err[i]);
            exp_q = keep;
            exp_err = keep_e;
        end
    endtask

    task automatic drive_all(output int base);
        base = cyc + 1;
        foreach (beats[j]) begin
            bus.i_sum   = beats[j].sum;
            bus.i_first = beats[j].first;
            bus.i_last  = beats[j].last;
            bus.i_pause = beats[j].pause;
            bus.i_shift = beats[j].shift;
            bus.i_relu  = beats[j].relu;
            rst         = beats[j].rst;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.i_pause = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic compare_run(input string tag);
        int n;
        check({tag, ".words"}, 256'(got_q.size()), 256'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.word%0d", tag, i), pk(got_q[i]), pk(exp_q[i]));
        check({tag, ".errs"}, 256'(got_err.size()), 256'(exp_err.size()));
        n = (got_err.size() < exp_err.size()) ? got_err.size() : exp_err.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.err%0d", tag, i), 256'(got_err[i]), 256'(exp_err[i]));
    endtask

    task automatic run_stream(input string tag);
        int base;
        drive_all(base);
        build_model(base);
        compare_run(tag);
    endtask

    task automatic flush();
        got_q.delete(); exp_q.delete(); got_err.delete(); exp_err.delete(); beats.delete();
    endtask

    task automatic gen_random(input int nvec);
        for (int v = 0; v < nvec; v++) begin
            int len;
            bit nofirst, nolast;
            len = $urandom_range(40, 1);
            nofirst = ($urandom_range(9, 0) == 0);
            nolast  = ($urandom_range(9, 0) == 0);
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(4, 0) == 0) add_pause();
                if ($urandom_range(59, 0) == 0) add_rst();
                add_beat(rand_sum(), (k == 0) && !nofirst, (k == len - 1) && !nolast,
                         ($urandom_range(9, 0) == 0) ? 6'($urandom_range(63, 48))
                                                     : 6'($urandom_range(40, 0)),
                         1'($urandom()));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        word_t q0[$];
        word_t w;
        int base;

        tbl[0]  = '{48'd1000,             6'd3,  1'b0, 8'h7D, 1'b0};
        tbl[1]  = '{48'd1020,             6'd3,  1'b0, 8'h7F, 1'b1};
        tbl[2]  = '{-48'sd1000,           6'd3,  1'b0, 8'h83, 1'b0};
        tbl[3]  = '{-48'sd5,              6'd0,  1'b1, 8'h00, 1'b0};
        tbl[4]  = '{48'd127,              6'd0,  1'b0, 8'h7F, 1'b0};
        tbl[5]  = '{-48'sd128,            6'd0,  1'b0, 8'h80, 1'b0};
        tbl[6]  = '{-48'sd129,            6'd0,  1'b0, 8'h80, 1'b1};
        tbl[7]  = '{48'd5,                6'd1,  1'b0, 8'h03, 1'b0};
        tbl[8]  = '{-48'sd5,              6'd1,  1'b0, 8'hFE, 1'b0};
        tbl[9]  = '{48'h7FFF_FFFF_FFFF,   6'd63, 1'b0, 8'h01, 1'b0};
        tbl[10] = '{48'h8000_0000_0000,   6'd63, 1'b0, 8'hFF, 1'b0};
        tbl[11] = '{48'd300,              6'd0,  1'b1, 8'h7F, 1'b1};
        tbl[12] = '{-48'sd6,              6'd2,  1'b0, 8'hFF, 1'b0};
        tbl[13] = '{48'd6,                6'd2,  1'b0, 8'h02, 1'b0};
        tbl[14] = '{-48'sd7,              6'd2,  1'b0, 8'hFE, 1'b0};

        rst = 1'b1;
        bus.i_sum = '0; bus.i_first = 1'b0; bus.i_last = 1'b0;
        bus.i_pause = 1'b1; bus.i_shift = '0; bus.i_relu = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.during", {bus.o_valid, bus.o_first, bus.o_last, bus.o_sat, bus.o_err,
                               bus.o_data, bus.o_lane_en}, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset.after", {bus.o_valid, bus.o_first, bus.o_last, bus.o_sat, bus.o_err,
                              bus.o_data, bus.o_lane_en}, '0);
        mon_on = 1'b1;

        // Single-item vectors from the table, including 3-cycle latency
        for (int i = 0; i < 15; i++) begin
            flush();
            add_beat(tbl[i].sum, 1'b1, 1'b1, tbl[i].sh, tbl[i].relu);
            drive_all(base);
            check($sformatf("tbl%0d.count", i), 256'(got_q.size()), 256'd1);
            if (got_q.size() > 0) begin
                w.stamp = base + 2; w.data = '0; w.data[N-1:0] = tbl[i].lane0;
                w.en = 16'h0001; w.first = 1'b1; w.last = 1'b1; w.sat = tbl[i].sat;
                check($sformatf("tbl%0d.word", i), pk(got_q[0]), pk(w));
            end
        end
        flush();

        // 256 items 0..255, shift 0
        for (int i = 0; i < 256; i++) add_beat(S'(i), i == 0, i == 255, 6'd0, 1'b0);
        run_stream("ramp");
        if (got_q.size() == 16) begin
            check("ramp.lane31", got_q[1].data[127:120], 8'h1F);
            check("ramp.en15", got_q[15].en, 16'hFFFF);
            check("ramp.flags", {got_q[0].first, got_q[0].last, got_q[15].first, got_q[15].last},
                  4'b1001);
        end
        flush();

        // 20 items without pauses, then the same items with junk pause beats
        for (int i = 0; i < 20; i++) add_beat(S'(i * 37 - 300), i == 0, i == 19, 6'd2, 1'b0);
        run_stream("np");
        q0 = got_q;
        beats.delete(); got_q.delete(); exp_q.delete(); got_err.delete(); exp_err.delete();
        for (int i = 0; i < 20; i++) begin
            while ($urandom_range(2, 0) == 0) add_pause();
            add_beat(S'(i * 37 - 300), i == 0, i == 19, (i == 0) ? 6'd2 : 6'($urandom()), 1'b0);
        end
        run_stream("pz");
        check("pz.count", 256'(got_q.size()), 256'd2);
        if (got_q.size() == 2 && q0.size() == 2) begin
            check("pz.en1", got_q[1].en, 16'h000F);
            check("pz.same0", got_q[0].data, q0[0].data);
            check("pz.same1", got_q[1].data, q0[1].data);
        end
        flush();

        // Stray beat while idle
        add_beat(48'd10, 1'b0, 1'b0, 6'd0, 1'b0);
        run_stream("fe_a");
        check("fe_a.errs", 256'(got_err.size()), 256'd1);
        flush();

        // Second first after 5 items: partial word dropped
        for (int i = 0; i < 5; i++) add_beat(S'(i + 1), i == 0, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) add_beat(S'(i + 50), i == 0, i == 2, 6'd0, 1'b0);
        run_stream("fe_b");
        check("fe_b.errs", 256'(got_err.size()), 256'd1);
        check("fe_b.count", 256'(got_q.size()), 256'd1);
        if (got_q.size() == 1) check("fe_b.data", got_q[0].data[23:0], 24'h343332);
        flush();

        // Shift/relu captured at the first beat
        add_beat(48'd400, 1'b1, 1'b0, 6'd2, 1'b0);
        add_beat(48'd400, 1'b0, 1'b1, 6'd0, 1'b0);
        run_stream("cap");
        if (got_q.size() == 1) check("cap.data", got_q[0].data[15:0], 16'h6464);
        flush();

        // Reset after 10 items, then a clean 16-item vector
        for (int i = 0; i < 10; i++) add_beat(S'(i + 3), i == 0, 1'b0, 6'd0, 1'b0);
        add_rst();
        for (int i = 0; i < 16; i++) add_beat(S'(i * 4), i == 0, i == 15, 6'd0, 1'b0);
        run_stream("rst");
        check("rst.count", 256'(got_q.size()), 256'd1);
        if (got_q.size() == 1) check("rst.en", got_q[0].en, 16'hFFFF);
        flush();

        // Randomized streams with occasional framing faults and resets
        for (int r = 0; r < 6; r++) begin
            gen_random(12);
            run_stream($sformatf("rnd%0d", r));
            flush();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
